// File: rtl/multdiv_controller_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: FSM state
// encoding, the ALU opcodes that launch it and the rstatus exception codes.
package multdiv_controller_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // ALU opcodes decoded into start_mult / start_div
   localparam logic [4:0] OP_MUL = 5'b00110;
   localparam logic [4:0] OP_DIV = 5'b00111;

   // Exception reporting
   localparam logic [4:0] RSTATUS_REG  = 5'd30;
   localparam int         MUL_OVF_CODE = 4;
   localparam int         DIV_OVF_CODE = 5;

endpackage

// File: rtl/multdiv_iter_core.sv
// Unsigned iterative datapath: one shift-add multiply step or one restoring
// divide step per 'step' cycle. A single 2*WIDTH accumulator serves both:
//   multiply: {partial product high, multiplier bits still to consume}
//   divide:   {partial remainder, dividend bits shifting into quotient bits}
// After WIDTH steps 'product' holds a*b and 'quotient' holds a/b.
module multdiv_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               op_div,
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [WIDTH-1:0]   b_mag,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   quotient
);

   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;

   // Combinational step arithmetic for both operations
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
      div_trial = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_trial - {1'b0, divisor};
   end

   // Accumulator and divisor/multiplicand registers
   always_ff @(posedge clock) begin
      if (reset) begin
         acc     <= '0;
         divisor <= '0;
      end else if (load) begin
         acc     <= {{WIDTH{1'b0}}, a_mag};
         divisor <= b_mag;
      end else if (step) begin
         if (op_div) begin
            // A borrow out of the trial subtraction means "restore"
            if (div_diff[WIDTH])
               acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
               acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
         end
      end
   end

   assign product  = acc;
   assign quotient = acc[WIDTH-1:0];

endmodule

// File: rtl/multdiv_controller.sv
// Sequencing controller for the multi-cycle signed multiply/divide unit.
// Latches operand magnitudes and result sign on a start pulse, runs the
// unsigned core for WIDTH cycles, applies sign correction and overflow
// detection, then emits a single writeback (result to rd, or an rstatus
// code to RSTATUS_REG). Divide-by-zero skips the iteration entirely.
//
// Handshake: start_mult/start_div are single-cycle requests honoured only in
// IDLE; stall is held from the start cycle through FIX; wb_valid is a
// one-cycle strobe in DONE and carries wb_we/wb_rd/wb_data/exception.
module multdiv_controller
   import multdiv_controller_pkg::*;
#(
   parameter int         WIDTH        = 32,
   parameter logic [4:0] RSTATUS_REG  = multdiv_controller_pkg::RSTATUS_REG,
   parameter int         MUL_OVF_CODE = multdiv_controller_pkg::MUL_OVF_CODE,
   parameter int         DIV_OVF_CODE = multdiv_controller_pkg::DIV_OVF_CODE
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [4:0]       rd_in,
   output logic             stall,
   output logic             busy,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [4:0]       wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic             exception,
   output logic [1:0]       fsm_state
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [1:0]         state;
   logic [1:0]         state_next;
   logic [CW-1:0]      count;
   logic               op_div;
   logic               neg_res;
   logic               div_ovf;
   logic [4:0]         rd_q;

   logic               start_any;
   logic               req_div;
   logic               div_zero;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               core_load;
   logic               core_step;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotient;

   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_signed;
   logic               mul_ovf;
   logic               fix_exc;
   logic [WIDTH-1:0]   fix_data;

   // Request decode and operand magnitudes (multiply wins a double start)
   always_comb begin
      start_any = start_mult | start_div;
      req_div   = start_div & ~start_mult;
      div_zero  = req_div & (operand_b == '0);
      a_mag     = operand_a[WIDTH-1] ? ('0 - operand_a) : operand_a;
      b_mag     = operand_b[WIDTH-1] ? ('0 - operand_b) : operand_b;
      core_load = (state == ST_IDLE) & start_any;
      core_step = (state == ST_RUN);
   end

   multdiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clock    (clock),
      .reset    (reset),
      .load     (core_load),
      .step     (core_step),
      .op_div   (op_div),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .product  (product),
      .quotient (quotient)
   );

   // Sign correction and overflow detection on the finished magnitudes
   always_comb begin
      prod_signed = neg_res ? ('0 - product) : product;
      quo_signed  = neg_res ? ('0 - quotient) : quotient;
      mul_ovf     = prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}};
      fix_exc     = op_div ? div_ovf : mul_ovf;
      fix_data    = op_div ? quo_signed : prod_signed[WIDTH-1:0];
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start_any) state_next = div_zero ? ST_DONE : ST_RUN;
         ST_RUN:  if (count == LAST) state_next = ST_FIX;
         ST_FIX:  state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State, operation context and writeback registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         count     <= '0;
         op_div    <= 1'b0;
         neg_res   <= 1'b0;
         div_ovf   <= 1'b0;
         rd_q      <= '0;
         busy      <= 1'b0;
         wb_valid  <= 1'b0;
         wb_we     <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         exception <= 1'b0;
      end else begin
         state     <= state_next;
         busy      <= (state_next == ST_RUN) || (state_next == ST_FIX);
         wb_valid  <= 1'b0;
         wb_we     <= 1'b0;
         exception <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_any) begin
                  op_div  <= req_div;
                  neg_res <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                  // The only signed quotient that does not fit: MIN / -1
                  div_ovf <= req_div && (operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                                     && (operand_b == {WIDTH{1'b1}});
                  rd_q    <= rd_in;
                  count   <= '0;
                  if (div_zero) begin
                     wb_valid  <= 1'b1;
                     wb_we     <= 1'b1;
                     exception <= 1'b1;
                     wb_rd     <= RSTATUS_REG;
                     wb_data   <= WIDTH'(DIV_OVF_CODE);
                  end
               end
            end
            ST_RUN: count <= count + 1'b1;
            ST_FIX: begin
               wb_valid <= 1'b1;
               if (fix_exc) begin
                  wb_we     <= 1'b1;
                  exception <= 1'b1;
                  wb_rd     <= RSTATUS_REG;
                  wb_data   <= op_div ? WIDTH'(DIV_OVF_CODE) : WIDTH'(MUL_OVF_CODE);
               end else begin
                  wb_we     <= (rd_q != 5'd0);
                  wb_rd     <= rd_q;
                  wb_data   <= fix_data;
               end
            end
            default: ;
         endcase
      end
   end

   // Stall covers the start cycle and every iterating cycle, but not DONE
   assign stall     = ((state == ST_IDLE) & start_any) | (state == ST_RUN) | (state == ST_FIX);
   assign fsm_state = state;

endmodule

// File: doc/multdiv_controller.md
Name: multdiv_controller

Overview:
- Multi-cycle signed multiply/divide unit plus its sequencing controller for the single-cycle processor.
- Decode raises a one-cycle start for ALU ops mul (5'b00110) and div (5'b00111).
- The block stalls PC/regfile writeback while it iterates, then issues one writeback: the result to rd, or an rstatus code to r30 on exception.
- Sits beside the ALU; its writeback port muxes into the regfile write path ahead of Rwd selection.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- RSTATUS_REG, 30, destination register for exception codes.
- MUL_OVF_CODE, 4, value written to RSTATUS_REG on multiply overflow.
- DIV_OVF_CODE, 5, value written to RSTATUS_REG on divide-by-zero or divide overflow.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start_mult  in  1  one-cycle request: signed operand_a*operand_b.
- start_div  in  1  one-cycle request: signed operand_a/operand_b.
- operand_a  in  WIDTH  multiplicand/dividend, sampled on the start edge.
- operand_b  in  WIDTH  multiplier/divisor, sampled on the start edge.
- rd_in  in  5  destination register, sampled on the start edge.
- stall  out  1  hold PC and suppress normal regfile write.
- busy  out  1  registered; high in RUN/FIX.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_we  out  1  regfile write enable accompanying wb_valid.
- wb_rd  out  5  writeback register.
- wb_data  out  WIDTH  writeback value.
- exception  out  1  high with wb_valid when an rstatus code is written.

Behaviour:
- Reset: state IDLE. busy, wb_valid, wb_we, exception, wb_rd, wb_data, counter and operand registers all 0. Reset in any state returns to IDLE on the next edge. An in-flight operation is discarded with no writeback.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On a start edge, latch operand magnitudes, result sign, op type and rd_in; clear counter.
  - start_mult has priority if both starts are high.
  - Div with operand_b==0 goes directly to DONE as an exception; otherwise go to RUN.
- RUN:
  - One shift-add (mul) or restoring-subtract (div) step per cycle on unsigned magnitudes.
  - Counter increments 0..WIDTH-1; on WIDTH-1 go to FIX.
- FIX:
  - Apply sign correction.
  - Mul overflow: the 64-bit signed product is not the sign extension of its low 32 bits.
  - Div overflow: 0x80000000 / 0xFFFFFFFF.
  - Go to DONE.
- DONE: wb_valid=1 for exactly one cycle, then IDLE.
- Normal writeback: wb_rd=rd, wb_data=low WIDTH bits of the product, or the quotient truncated toward zero (remainder discarded). wb_we=(rd!=0).
- Exception writeback: wb_rd=RSTATUS_REG, wb_data=MUL_OVF_CODE or DIV_OVF_CODE, wb_we=1, exception=1.
- Timing, with cycle 0 = cycle where start is high:
  - RUN occupies cycles 1..32, FIX cycle 33, DONE cycle 34.
  - Divide-by-zero: DONE in cycle 1.
- stall = (IDLE & (start_mult|start_div)) | RUN | FIX. It is combinational and low during DONE so the processor advances in the writeback cycle.
- Starts arriving in RUN/FIX/DONE are ignored (not queued).
- A start in the cycle immediately after DONE (back in IDLE) is accepted normally.
- Operand inputs may change after the start edge without effect.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/RUN/FIX/DONE);
  - opcode constants OP_MUL=5'b00110, OP_DIV=5'b00111;
  - RSTATUS_REG, MUL_OVF_CODE, DIV_OVF_CODE.
- One sub-module, multdiv_iter_core: the unsigned 32-iteration shift-add/restoring-subtract datapath, with load/step/op inputs, 64-bit product and 32-bit quotient outputs.
- The FSM, sign handling, exception detection and writeback formatting stay in multdiv_controller.

Test Plan:
- Mult 7 * -3, rd=5, start cycle 0 -> stall high cycles 0-33. Cycle 34: wb_valid=1, wb_rd=5, wb_data=0xFFFFFFEB, wb_we=1, exception=0.
- Mult 0x00010000*0x00010000, rd=3 -> cycle 34: wb_rd=30, wb_data=4, exception=1.
- Div -7/2, rd=8 -> cycle 34: wb_data=0xFFFFFFFD. Then a 0x80000000/0xFFFFFFFF start in cycle 35 -> wb_rd=30, wb_data=5 at its cycle 34.
- Div 9/0, rd=4 -> cycle 1: wb_valid=1, wb_rd=30, wb_data=5; stall low from cycle 1; busy never high.
- Mult with rd=0 -> wb_valid=1, wb_we=0 at cycle 34. A start_div pulsed in cycle 10 of that op is ignored: exactly one wb_valid.
- Start mult cycle 0, reset high cycle 12 -> from cycle 13 state is IDLE, stall=0, busy=0; no wb_valid ever appears.
